sram_master: RTL and testbench

//  Initiator for the single-port DPI SRAM request interface (req/wr/addr/wdata/wmask -> rdata).

---
 rtl/sram_master.sv | 132 +++++++++++++
 tb/tb_sram_master.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/sram_master.sv
// Single-outstanding load/store initiator for the single-port SRAM request interface.
// Aligns store data/masks on accept, strobes the SRAM once, waits the read latency, extends load data.
module sram_master #(
  parameter int unsigned RD_LATENCY  = 1,
  parameter bit          ALIGN_CHECK = 1'b1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        sram_req,
  output logic        sram_wr,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic [7:0]  sram_wmask,
  input  logic [31:0] sram_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state, state_nxt;
  logic        wr_q, uns_q, err_q;
  logic [1:0]  size_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wmask_q;
  logic [2:0]  cnt;
  logic        misaligned;
  logic [3:0]  base_mask;
  logic [31:0] shifted, extended;

  always_comb begin
    misaligned = 1'b0;
    if (ALIGN_CHECK) begin
      case (req_size)
        2'd0:    misaligned = 1'b0;
        2'd1:    misaligned = req_addr[0];
        default: misaligned = |req_addr[1:0];
      endcase
    end
  end

  always_comb begin
    case (req_size)
      2'd0:    base_mask = 4'b0001;
      2'd1:    base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
  end

  // Load data sits in the lane selected by the low address bits; bring it down before extending.
  always_comb begin
    shifted = sram_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'd0:    extended = uns_q ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
      2'd1:    extended = uns_q ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: extended = shifted;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = misaligned ? RESP : ISSUE;
      ISSUE:   state_nxt = wr_q ? RESP : WAIT;
      WAIT:    if (cnt == 3'd1) state_nxt = RESP;
      RESP:    if (resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (state == IDLE);
    resp_valid = (state == RESP);
    resp_err   = (state == RESP) && err_q;
    resp_rdata = rdata_q;
    sram_req   = (state == ISSUE);
    sram_wr    = (state == ISSUE) && wr_q;
    sram_addr  = {addr_q[31:2], 2'b00};
    sram_wdata = wdata_q;
    sram_wmask = {4'b0000, wmask_q};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            wr_q    <= req_wr;
            uns_q   <= req_unsigned;
            err_q   <= misaligned;
            size_q  <= req_size;
            addr_q  <= req_addr;
            wdata_q <= req_wdata << {req_addr[1:0], 3'b000};
            wmask_q <= req_wr ? (base_mask << req_addr[1:0]) : 4'b0000;
            rdata_q <= '0;
          end
        end
        ISSUE: cnt <= 3'(RD_LATENCY);
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) rdata_q <= extended;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_master.sv
// Directed bench for sram_master: scoreboarded responses, latency, SRAM-side fields, backpressure, async reset.
module tb_sram_master;

  logic        clock, reset_n;
  logic        req_valid, req_ready, req_wr, req_unsigned;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic        sram_req, sram_wr;
  logic [31:0] sram_addr, sram_wdata, sram_rdata;
  logic [7:0]  sram_wmask;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } resp_t;

  resp_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] mem [16];

  sram_master #(.RD_LATENCY(1), .ALIGN_CHECK(1'b1)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size),
    .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sram_req(sram_req), .sram_wr(sram_wr), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_wmask(sram_wmask), .sram_rdata(sram_rdata)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // One-cycle registered SRAM with byte-masked writes.
  always @(posedge clock) begin
    if (sram_req) begin
      if (sram_wr) begin
        for (int b = 0; b < 4; b++)
          if (sram_wmask[b]) mem[sram_addr[5:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
      end else begin
        sram_rdata <= mem[sram_addr[5:2]];
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns,
                       input logic [31:0] exp_rdata, input logic exp_err, input logic keep);
    int    waited = 0;
    resp_t e;
    @(negedge clock);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns;
    while (!req_ready && waited < 20) begin
      @(negedge clock);
      waited++;
    end
    chk("accept_timeout", 32'(waited < 20), 32'd1);
    @(posedge clock);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    exp_q.push_back(e);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input int exp_lat, input int exp_nreq,
                             input logic exp_wr, input logic [31:0] exp_addr,
                             input logic [31:0] exp_wdata, input logic [7:0] exp_wmask,
                             input int hold);
    int          n = 0, nreq = 0;
    logic        w = 1'b0;
    logic [31:0] a = '0, wd = '0;
    logic [7:0]  wm = '0;
    resp_t       e;
    while (n < 40) begin
      @(negedge clock);
      n++;
      if (sram_req) begin
        nreq++; w = sram_wr; a = sram_addr; wd = sram_wdata; wm = sram_wmask;
      end
      if (resp_valid) break;
    end
    chk({tag, "_latency"}, 32'(n), 32'(exp_lat));
    chk({tag, "_sram_req_count"}, 32'(nreq), 32'(exp_nreq));
    if (nreq > 0) begin
      chk({tag, "_sram_wr"}, 32'(w), 32'(exp_wr));
      chk({tag, "_sram_addr"}, a, exp_addr);
      chk({tag, "_sram_wmask"}, 32'(wm), 32'(exp_wmask));
      if (exp_wr) chk({tag, "_sram_wdata"}, wd, exp_wdata);
    end
    if (exp_q.size() == 0) begin
      chk({tag, "_scoreboard_empty"}, 32'd0, 32'(exp_q.size() + 1));
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_err"}, 32'(resp_err), 32'(e.err));
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        chk({tag, "_hold_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
        chk({tag, "_hold_req_ready"}, 32'(req_ready), 32'd0);
      end
    end
    @(negedge clock);
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_wr = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; resp_ready = 1'b0;
    repeat (3) @(negedge clock);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_sram_req", 32'(sram_req), 32'd0);
    chk("rst_sram_wr", 32'(sram_wr), 32'd0);
    chk("rst_sram_addr", sram_addr, 32'd0);
    chk("rst_sram_wdata", sram_wdata, 32'd0);
    chk("rst_sram_wmask", 32'(sram_wmask), 32'd0);
    reset_n = 1'b1;

    issue(1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("st_word", 2, 1, 1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 8'h0F, 0);

    issue(1'b1, 32'h8000_0000, 32'h8011_2233, 2'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("st_word0", 2, 1, 1'b1, 32'h8000_0000, 32'h8011_2233, 8'h0F, 0);

    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 32'hFFFF_FF80, 1'b0, 1'b0);
    finish_resp("ld_byte_s", 3, 1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0);

    issue(1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 32'h0000_0080, 1'b0, 1'b0);
    finish_resp("ld_byte_u", 3, 1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0);

    issue(1'b1, 32'h8000_0002, 32'h0000_ABCD, 2'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("st_half", 2, 1, 1'b1, 32'h8000_0000, 32'hABCD_0000, 8'h0C, 0);

    issue(1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 32'hFFFF_ABCD, 1'b0, 1'b0);
    finish_resp("ld_half_s", 3, 1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0);

    issue(1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b1, 32'h0000_2233, 1'b0, 1'b0);
    finish_resp("ld_half_u", 3, 1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0);

    issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0);
    finish_resp("ld_word", 3, 1, 1'b0, 32'h8000_0004, 32'h0, 8'h00, 0);

    issue(1'b0, 32'h8000_0001, 32'h0, 2'd2, 1'b0, 32'h0, 1'b1, 1'b0);
    finish_resp("mis_word", 1, 0, 1'b0, 32'h0, 32'h0, 8'h00, 0);

    issue(1'b1, 32'h8000_0003, 32'h1234, 2'd1, 1'b0, 32'h0, 1'b1, 1'b0);
    finish_resp("mis_half", 1, 0, 1'b0, 32'h0, 32'h0, 8'h00, 0);

    issue(1'b1, 32'h8000_0005, 32'h0000_0077, 2'd0, 1'b0, 32'h0, 1'b0, 1'b0);
    finish_resp("st_byte", 2, 1, 1'b1, 32'h8000_0004, 32'h0000_7700, 8'h02, 0);

    // Backpressure: next request already presented while the response is stalled.
    issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_77EF, 1'b0, 1'b1);
    req_addr = 32'h8000_0004; req_size = 2'd0; req_unsigned = 1'b1;
    finish_resp("bp_word", 3, 1, 1'b0, 32'h8000_0004, 32'h0, 8'h00, 5);
    @(negedge clock);
    chk("bp_next_ready", 32'(req_ready), 32'd1);
    @(posedge clock);
    exp_q.push_back('{rdata: 32'h0000_00EF, err: 1'b0});
    #1 req_valid = 1'b0;
    finish_resp("bp_next", 3, 1, 1'b0, 32'h8000_0004, 32'h0, 8'h00, 0);

    // Reset in WAIT discards the access.
    issue(1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 32'hDEAD_77EF, 1'b0, 1'b0);
    @(negedge clock);
    chk("rw_issue_req", 32'(sram_req), 32'd1);
    @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    chk("rw_sram_req", 32'(sram_req), 32'd0);
    chk("rw_resp_valid", 32'(resp_valid), 32'd0);
    chk("rw_req_ready", 32'(req_ready), 32'd1);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clock);
    chk("rw_still_idle", 32'(resp_valid), 32'd0);
    reset_n = 1'b1;
    issue(1'b0, 32'h8000_0000, 32'h0, 2'd2, 1'b0, 32'hABCD_2233, 1'b0, 1'b0);
    finish_resp("rw_after", 3, 1, 1'b0, 32'h8000_0000, 32'h0, 8'h00, 0);

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
